// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between register-read and writeback stages.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num_1;
  logic [WIDTH-1:0] num_2;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, num_1, num_2, opcode, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, negative, busy
  );

  modport slave (
    input  in_valid, num_1, num_2, opcode, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, negative, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, stored carry and a shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q;
  logic               carry_flag_q, carry_flag_d;
  logic               ovf_q, ovf_d;
  logic               carry_q, carry_q_d;

  logic               in_ready;
  logic               accept;
  logic [ACC_W-1:0]   acc_step;
  logic [WIDTH:0]     add_sum, adc_sum, sub_diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;
  logic [WIDTH-1:0]   a, b;

  assign a        = bus.num_1;
  assign b        = bus.num_2;
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle ALU: result, carry/borrow and signed overflow for every opcode.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    add_sum   = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    adc_sum   = add_sum + (WIDTH+1)'(carry_q);
    sub_diff  = (WIDTH+1)'(a) - (WIDTH+1)'(b);
    case (bus.opcode)
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res   = a << 1;
        alu_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = a >> 1;
        alu_carry = a[0];
      end
      OP_ADC: begin
        alu_res   = adc_sum[WIDTH-1:0];
        alu_carry = adc_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (adc_sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
    endcase
  end

  // Next-state: accept/launch in IDLE, one partial-product step per MUL cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    carry_flag_d = carry_flag_q;
    ovf_d        = ovf_q;
    carry_q_d    = carry_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.opcode == OP_MUL) begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            out_valid_d  = 1'b1;
            result_d     = alu_res;
            carry_flag_d = alu_carry;
            ovf_d        = alu_ovf;
            carry_q_d    = alu_carry;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          result_d     = acc_step[WIDTH-1:0];
          carry_flag_d = |acc_step[ACC_W-1:WIDTH];
          ovf_d        = 1'b0;
          carry_q_d    = |acc_step[ACC_W-1:WIDTH];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      carry_flag_q <= 1'b0;
      ovf_q        <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      zero_q       <= (result_d == '0);
      carry_flag_q <= carry_flag_d;
      ovf_q        <= ovf_d;
      carry_q      <= carry_q_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_flag_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = result_q[WIDTH-1];
  assign bus.busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with hand-computed expectations.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait (bounded) for in_ready, then let it be accepted.
  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    int n;
    bus.opcode   = op;
    bus.num_1    = x;
    bus.num_2    = y;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.num_1     = '0;
    bus.num_2     = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD with wrap-around
    issue(4'd0, 16'hFFFF, 16'h0001);
    check("add_valid",  32'(bus.out_valid), 32'd1);
    check("add_result", 32'(bus.result),    32'h0000);
    check("add_zero",   32'(bus.zero),      32'd1);
    check("add_carry",  32'(bus.carry),     32'd1);
    check("add_ovf",    32'(bus.overflow),  32'd0);

    // SUB with borrow, then signed overflow
    issue(4'd1, 16'h0003, 16'h0005);
    check("sub_result", 32'(bus.result),   32'hFFFE);
    check("sub_borrow", 32'(bus.carry),    32'd1);
    check("sub_neg",    32'(bus.negative), 32'd1);
    check("sub_zero",   32'(bus.zero),     32'd0);
    check("sub_ovf0",   32'(bus.overflow), 32'd0);
    issue(4'd1, 16'h8000, 16'h0001);
    check("subov_result", 32'(bus.result),   32'h7FFF);
    check("subov_ovf",    32'(bus.overflow), 32'd1);
    check("subov_carry",  32'(bus.carry),    32'd0);
    check("subov_neg",    32'(bus.negative), 32'd0);

    // ADD then ADC back-to-back
    bus.opcode = 4'd0; bus.num_1 = 16'hFFFF; bus.num_2 = 16'h0002; bus.in_valid = 1'b1;
    check("b2b_ready0", 32'(bus.in_ready), 32'd1);
    step();
    check("b2b_add_result", 32'(bus.result), 32'h0001);
    check("b2b_add_carry",  32'(bus.carry),  32'd1);
    bus.opcode = 4'd9; bus.num_1 = 16'h0001; bus.num_2 = 16'h0001;
    check("b2b_ready1", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_adc_valid",  32'(bus.out_valid), 32'd1);
    check("b2b_adc_result", 32'(bus.result),    32'h0003);
    check("b2b_adc_carry",  32'(bus.carry),     32'd0);

    // MUL with a nonzero high half
    issue(4'd8, 16'h0100, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      check("mul_busy",     32'(bus.busy),      32'd1);
      check("mul_in_ready", 32'(bus.in_ready),  32'd0);
      check("mul_no_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    check("mul_valid",  32'(bus.out_valid), 32'd1);
    check("mul_busy0",  32'(bus.busy),      32'd0);
    check("mul_result", 32'(bus.result),    32'h0000);
    check("mul_carry",  32'(bus.carry),     32'd1);
    check("mul_zero",   32'(bus.zero),      32'd1);
    check("mul_ovf",    32'(bus.overflow),  32'd0);

    issue(4'd8, 16'h00FF, 16'h0003);
    wait_out("mul2_valid");
    check("mul2_result", 32'(bus.result), 32'h02FD);
    check("mul2_carry",  32'(bus.carry),  32'd0);
    step();

    // Backpressure holds the result; next op accepted in the transfer cycle
    bus.out_ready = 1'b0;
    issue(4'd0, 16'h1234, 16'h0001);
    check("bp_valid",  32'(bus.out_valid), 32'd1);
    check("bp_result", 32'(bus.result),    32'h1235);
    bus.opcode = 4'd4; bus.num_1 = 16'h00FF; bus.num_2 = 16'h0F0F; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_ready",  32'(bus.in_ready),  32'd0);
      check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
      check("bp_hold_result", 32'(bus.result),    32'h1235);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_xor_valid",  32'(bus.out_valid), 32'd1);
    check("bp_xor_result", 32'(bus.result),    32'h0FF0);

    // Reset in the middle of a multiply
    issue(4'd8, 16'h0003, 16'h0005);
    for (int i = 0; i < 4; i++) step();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result",   32'(bus.result),    32'd0);
    check("mid_rst_busy",     32'(bus.busy),      32'd0);
    check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("mid_no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    check("mid_rel_busy", 32'(bus.busy), 32'd0);

    // Shifts, NOT, undefined opcode and its effect on the stored carry
    issue(4'd6, 16'h8001, 16'h0000);
    check("shl_result", 32'(bus.result), 32'h0002);
    check("shl_carry",  32'(bus.carry),  32'd1);
    issue(4'd7, 16'h0003, 16'h0000);
    check("shr_result", 32'(bus.result), 32'h0001);
    check("shr_carry",  32'(bus.carry),  32'd1);
    issue(4'd5, 16'h00FF, 16'h0000);
    check("not_result", 32'(bus.result),   32'hFF00);
    check("not_neg",    32'(bus.negative), 32'd1);
    check("not_carry",  32'(bus.carry),    32'd0);
    issue(4'd7, 16'h0001, 16'h0000);
    check("shr2_carry", 32'(bus.carry), 32'd1);
    issue(4'd15, 16'h1234, 16'h5678);
    check("undef_result", 32'(bus.result), 32'd0);
    check("undef_zero",   32'(bus.zero),   32'd1);
    check("undef_carry",  32'(bus.carry),  32'd0);
    issue(4'd9, 16'h0001, 16'h0001);
    check("adc_after_undef", 32'(bus.result), 32'h0002);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Operand width is generic. Input and output use valid/ready handshakes.
- Adds a multi-cycle shift-add multiplier, add-with-carry using a stored carry flag, and overflow and negative flags.
- Sits between the operand/register-read stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits (must be at least 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block accepts an operation this cycle.
- num_1  input  WIDTH  first operand.
- num_2  input  WIDTH  second operand.
- opcode  input  4  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  registered; set when result == 0.
- carry  output  1  registered carry or borrow flag.
- overflow  output  1  registered signed-overflow flag.
- negative  output  1  registered; equals result[WIDTH-1].
- busy  output  1  high while a multiply is in progress.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - out_valid, result, zero, carry, overflow, negative, busy, and the internal carry_q all go to 0.
  - in_ready is 0 during reset.
  - Reset during a multiply aborts it; no result is produced.
- Handshake:
  - An operation is accepted when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - The output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, result and all flags hold stable.
  - Accepting a new operation in the same cycle the old result transfers is allowed, giving back-to-back throughput of 1 per cycle.
- Single-cycle ops: the result is registered at the accept edge, so out_valid rises the next cycle (latency 1).
  - 0 ADD: result = num_1 + num_2; carry = carry-out; overflow = signed overflow.
  - 1 SUB: result = num_1 - num_2; carry = borrow (num_1 < num_2 unsigned); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: carry = 0, overflow = 0.
  - 5 NOT: result = ~num_1; carry = 0, overflow = 0.
  - 6 SHL: result = num_1 << 1; carry = num_1[WIDTH-1]; overflow = 0.
  - 7 SHR (logical): result = num_1 >> 1; carry = num_1[0]; overflow = 0.
  - 9 ADC: result = num_1 + num_2 + carry_q; carry and overflow as for ADD.
  - 10–15 (undefined): result = 0, zero = 1, carry = 0, overflow = 0.
- Multi-cycle op 8 MUL (unsigned, shift-add):
  - At accept, the FSM goes IDLE -> MUL and latches the operands; busy = 1; in_ready = 0.
  - Exactly WIDTH cycles are spent in MUL, one partial-product step per cycle, with a 2*WIDTH accumulator.
  - Then FSM -> IDLE with out_valid = 1 and busy = 0. Latency is WIDTH+1 cycles from accept to out_valid.
  - result = low WIDTH bits of the product; carry = 1 if the high WIDTH bits are nonzero; overflow = 0.
- Flags:
  - zero and negative always derive from the registered result.
  - carry_q is updated with the produced carry flag whenever a result is produced (every opcode, including undefined).
  - ADC uses carry_q as it stood before the accept edge.
- FSM states: IDLE, MUL. There are no other states. An illegal state encoding recovers to IDLE.
- in_valid while busy: ignored; the operation is not accepted and the producer must hold it.

Test Plan:
- Reset, then ADD 0xFFFF+0x0001 with out_ready=1 -> one cycle later result=0x0000, zero=1, carry=1, overflow=0.
- SUB 0x0003-0x0005 -> result=0xFFFE, carry=1, negative=1, zero=0; SUB 0x8000-0x0001 -> result=0x7FFF, overflow=1.
- ADD 0xFFFF+0x0002 then ADC 0x0001+0x0001 back-to-back -> results 0x0001 (carry=1), then 0x0003 (carry=0).
- MUL 0x0100*0x0100 -> busy high and in_ready low for 16 cycles; out_valid on cycle 17; result=0x0000, carry=1, zero=1. MUL 0x00FF*0x0003 -> 0x02FD, carry=0.
- Backpressure: out_ready=0 after ADD 0x1234+0x0001 -> result holds 0x1235 and in_ready=0 until out_ready=1; the next op is accepted in the transfer cycle.
- Assert rst_n=0 mid-MUL (cycle 5) -> all outputs 0 immediately; after release, in_ready=1 and no stale out_valid appears. Also check opcode 4'b1111 -> result=0, zero=1.
